bus_arbiter4: RTL

//  Round-robin arbiter/sequencer sharing one 32-bit slave port among 4 requesters.

---
 rtl/bus_arbiter4_pkg.sv | 26 ++
 rtl/bus_arbiter4_rr_pick4.sv | 34 +++
 rtl/bus_arbiter4.sv | 96 +++++++++
 3 files changed

// File: rtl/bus_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter4_pkg
// Description : Shared types and helpers for the 4-requester bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter4_pkg;

  localparam int NREQ = 4;

  // Arbiter FSM state encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Requester index to one-hot vector
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter4_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Rotating-priority encoder. Starting just after the last
//               winner, returns the first requester whose req bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Scan last+1, last+2, last+3, last (mod 4); first set bit wins
  always_comb begin
    idx  = last;
    any  = 1'b0;
    cand = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter4
// Description : Round-robin arbiter sharing one slave port among 4
//               requesters. One transaction at a time; the grant is held
//               until the slave acks or the busy timer expires.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,  // 0 disables the timeout
  parameter int TW          = 8    // timer width, TIMEOUT_CYC < 2**TW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       slv_ack,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       slv_req,
  output logic [3:0] done,
  output logic [3:0] tmo,
  output logic       busy
);

  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  arb_state_t    state;
  logic [1:0]    last;
  logic [TW-1:0] timer;
  logic [1:0]    pick_idx;
  logic          pick_any;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Arbitration FSM with busy timer; every output is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel     <= 2'd0;
      gnt     <= 4'b0000;
      slv_req <= 1'b0;
      done    <= 4'b0000;
      tmo     <= 4'b0000;
      busy    <= 1'b0;
      last    <= 2'd3;
      timer   <= '0;
    end else begin
      done <= 4'b0000;
      tmo  <= 4'b0000;
      case (state)
        ST_IDLE: begin
          // sel keeps its previous value when nobody requests
          if (pick_any) begin
            state   <= ST_BUSY;
            gnt     <= onehot4(pick_idx);
            sel     <= pick_idx;
            slv_req <= 1'b1;
            busy    <= 1'b1;
            timer   <= '0;
          end
        end
        ST_BUSY: begin
          // Ack takes precedence over a simultaneous timer expiry
          if (slv_ack) begin
            state   <= ST_IDLE;
            gnt     <= 4'b0000;
            slv_req <= 1'b0;
            busy    <= 1'b0;
            done    <= onehot4(sel);
            last    <= sel;
          end else if (TMO_EN && (timer == TMO_LAST)) begin
            state   <= ST_IDLE;
            gnt     <= 4'b0000;
            slv_req <= 1'b0;
            busy    <= 1'b0;
            tmo     <= onehot4(sel);
            last    <= sel;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
